// File: rtl/access_rr_arbiter3.sv
// Round-robin burst arbiter for the 3:1 one-hot access mux.
// Sources: 0 = ifmap, 1 = filter, 2 = psum. A grant is held for a whole burst,
// which ends on the granted source's last beat or after MAX_BURST beats. Every
// burst is followed by one idle cycle in which sel is 000.
module access_rr_arbiter3 #(
  parameter  int MAX_BURST = 16,
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           req_valid,
  input  logic [2:0]           req_last,
  output logic [2:0]           req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           sel,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Beat index at which a burst is forcibly released if last has not arrived.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);

  // rr_ptr holds the one-hot code of the last source served. The search starts
  // at the source after it, so the last winner has lowest priority next time.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                         input logic [2:0] req);
    logic [2:0] win;
    win = 3'b000;
    case (ptr)
      3'b001: begin                       // order 1, 2, 0
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      3'b010: begin                       // order 2, 0, 1
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin                      // 3'b100: order 0, 1, 2
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
    return win;
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                 in_grant;
  logic                 beat;
  logic                 burst_end;
  logic                 release_now;
  logic [2:0]           winner;

  // Handshake toward the sources and the consumer; sel is registered, so
  // out_ready never reaches sel combinationally.
  always_comb begin
    in_grant    = (state_q == GRANT);
    out_valid   = in_grant & (|(req_valid & sel_q));
    req_ready   = in_grant ? (sel_q & {3{out_ready}}) : 3'b000;
    beat        = out_valid & out_ready;
    burst_end   = (|(req_last & sel_q)) | (beat_cnt_q == LAST_CNT);
    release_now = beat & burst_end;
    winner      = rr_pick(rr_ptr_q, req_valid);
  end

  // Next-state logic: pick a winner in IDLE, count beats and release in GRANT.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d    = GRANT;
          sel_d      = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          sel_d      = 3'b000;
          beat_cnt_d = '0;
          rr_ptr_d   = sel_q;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        sel_d      = 3'b000;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight and restores source 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 3'b000;
      rr_ptr_q   <= 3'b100;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q == GRANT);
  assign beat_cnt = beat_cnt_q;

`ifndef SYNTHESIS
  // The mux relies on sel being zero or exactly one-hot.
  a_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(sel_q));
  // A grant always carries a select and IDLE never does.
  a_busy_sel : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (sel_q != 3'b000));
  // The last-served pointer is always one-hot.
  a_ptr_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot(rr_ptr_q));
`endif

endmodule
